// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bundle between the multicycle controller and its datapath
//
// Purpose: carries the decoded instruction fields and the ALU zero flag
// into the controller, and the datapath enables and selects back out.
// Signals:
//   opcode[6:0], funct3[2:0], funct7_5, zero  : datapath -> controller
//   pc_write, adr_src, mem_write, ir_write,
//   reg_write                                  : controller -> datapath, 1 bit
//   result_src, alu_src_a, alu_src_b [1:0]     : controller -> datapath muxes
//   alu_control[2:0], sel_ext[2:0]             : ALU op / immediate format
//   illegal_instr, instr_done                  : one-cycle status pulses
// Modports: master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] sel_ext;
  logic       illegal_instr;
  logic       instr_done;

  modport master (
    input  opcode, funct3, funct7_5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, sel_ext,
           illegal_instr, instr_done
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, sel_ext,
           illegal_instr, instr_done
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM controller for a multicycle RV32I-subset datapath
//
// Purpose: sequences fetch, decode and the per-class execute/writeback
// states, driving the datapath enables and mux selects.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset, forces FETCH
//   ctrl  : multicycle_controller_if.master (instruction fields and zero
//           in, datapath controls and status pulses out)
// Per-state outputs are registered alongside the state. sel_ext is
// decoded straight from opcode; pc_write in BRANCH, illegal_instr in
// DECODE are the only terms that look at live inputs.
module multicycle_controller (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  ctrl
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALLINK,
    S_LUI, S_AUIPC
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       instr_done;
  } ctrl_t;

  state_t state;
  ctrl_t  outs;
  logic   branch_take;
  logic   legal_op;

  function automatic state_t next_of(input state_t s, input logic [6:0] op);
    case (s)
      S_FETCH:   next_of = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_of = S_MEMADR;
          OP_RTYPE:          next_of = S_EXECR;
          OP_ITYPE:          next_of = S_EXECI;
          OP_BRANCH:         next_of = S_BRANCH;
          OP_JAL:            next_of = S_JAL;
          OP_JALR:           next_of = S_JALR;
          OP_LUI:            next_of = S_LUI;
          OP_AUIPC:          next_of = S_AUIPC;
          default:           next_of = S_FETCH;
        endcase
      end
      S_MEMADR:  next_of = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: next_of = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL, S_AUIPC: next_of = S_ALUWB;
      S_JALR:    next_of = S_JALLINK;
      default:   next_of = S_FETCH;
    endcase
  endfunction

  // funct3 000 is sub only for R-type with funct7[5] set; I-type addi has no sub.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f75,
                                         input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f75) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  function automatic ctrl_t outs_of(input state_t s, input logic [2:0] f3,
                                    input logic f75);
    ctrl_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.ir_write = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        o.pc_write = 1'b1;
      end
      S_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      S_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      S_MEMREAD:  o.adr_src = 1'b1;
      S_MEMWB: begin
        o.result_src = 2'b01; o.reg_write = 1'b1; o.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        o.adr_src = 1'b1; o.mem_write = 1'b1; o.instr_done = 1'b1;
      end
      S_EXECR: begin
        o.alu_src_a = 2'b10; o.alu_control = alu_dec(f3, f75, 1'b1);
      end
      S_EXECI: begin
        o.alu_src_a = 2'b10; o.alu_src_b = 2'b01;
        o.alu_control = alu_dec(f3, f75, 1'b0);
      end
      S_ALUWB:    begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
      // pc_write here is the Mealy term, added outside the register.
      S_BRANCH: begin
        o.alu_src_a = 2'b10; o.alu_control = ALU_SUB; o.instr_done = 1'b1;
      end
      S_JAL: begin
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1;
      end
      S_JALR: begin
        o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.result_src = 2'b10;
        o.pc_write = 1'b1;
      end
      S_JALLINK: begin
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        o.reg_write = 1'b1; o.instr_done = 1'b1;
      end
      S_LUI: begin
        o.result_src = 2'b11; o.reg_write = 1'b1; o.instr_done = 1'b1;
      end
      S_AUIPC:    begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      default:    o = '0;
    endcase
    return o;
  endfunction

  // Outputs are registered for the state being entered, so they line up
  // with the state register on every edge, including the reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      outs  <= outs_of(S_FETCH, ctrl.funct3, ctrl.funct7_5);
    end else begin
      state <= next_of(state, ctrl.opcode);
      outs  <= outs_of(next_of(state, ctrl.opcode), ctrl.funct3, ctrl.funct7_5);
    end
  end

  always_comb begin
    case (ctrl.funct3)
      3'b000:  branch_take = ctrl.zero;
      3'b001:  branch_take = ~ctrl.zero;
      default: branch_take = 1'b0;
    endcase
  end

  always_comb begin
    case (ctrl.opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  end

  always_comb begin
    case (ctrl.opcode)
      OP_STORE:         ctrl.sel_ext = 3'b001;
      OP_BRANCH:        ctrl.sel_ext = 3'b010;
      OP_JAL:           ctrl.sel_ext = 3'b011;
      OP_LUI, OP_AUIPC: ctrl.sel_ext = 3'b100;
      default:          ctrl.sel_ext = 3'b000;
    endcase
  end

  assign ctrl.pc_write      = outs.pc_write | ((state == S_BRANCH) & branch_take);
  assign ctrl.adr_src       = outs.adr_src;
  assign ctrl.mem_write     = outs.mem_write;
  assign ctrl.ir_write      = outs.ir_write;
  assign ctrl.reg_write     = outs.reg_write;
  assign ctrl.result_src    = outs.result_src;
  assign ctrl.alu_src_a     = outs.alu_src_a;
  assign ctrl.alu_src_b     = outs.alu_src_b;
  assign ctrl.alu_control   = outs.alu_control;
  // Status pulses are masked while reset is high, even mid-instruction.
  assign ctrl.instr_done    = outs.instr_done & ~reset;
  assign ctrl.illegal_instr = (state == S_DECODE) & ~legal_op & ~reset;

endmodule
